indexed_array_store: RTL and testbench

// - Parametrised array store: DEPTH entries of WIDTH bits, one write port, NUM_RD independent read channels.
// - Each read returns an Option-encoded word {tag, payload}; tag 0 = Some, tag 1 = None.
// - Registered, 1-cycle read latency; out-of-range indices yield None instead of aliasing.
// - Sits behind Spade array-index lowering wherever a mutable, multi-reader table is needed.

---
 rtl/indexed_array_pkg.sv | 20 ++
 rtl/array_read_port.sv | 63 ++++++
 rtl/indexed_array_store.sv | 73 +++++++
 tb/tb_indexed_array_store.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/indexed_array_pkg.sv
// Option-word encoding shared by indexed_array_store and its read ports.
// Helpers work on a wide word; callers keep the tag bit and the low WIDTH payload bits.
package indexed_array_pkg;

    localparam logic TAG_SOME  = 1'b0;
    localparam logic TAG_NONE  = 1'b1;
    localparam int   MAX_WIDTH = 128;

    typedef logic [MAX_WIDTH-1:0] payload_max_t;
    typedef logic [MAX_WIDTH:0]   option_max_t;

    function automatic option_max_t opt_some(input payload_max_t payload);
        return {TAG_SOME, payload};
    endfunction

    function automatic option_max_t opt_none();
        return {TAG_NONE, payload_max_t'(0)};
    endfunction

endpackage

// File: rtl/array_read_port.sv
// One read channel: range check, optional write-first bypass, registered Option output.
// Build macro: INDEXED_ARRAY_STORE_BYPASS_EN selects write-first forwarding.
module array_read_port
    import indexed_array_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    parameter int IDX_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [IDX_W-1:0]       index,
    input  logic [DEPTH*WIDTH-1:0] entries,
    input  logic                   wr_commit,
    input  logic [IDX_W-1:0]       wr_index,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   valid,
    output logic [WIDTH:0]         result
);

    // One extra bit so DEPTH == 2**IDX_W still compares correctly.
    localparam logic [IDX_W:0] DEPTH_EXT = (IDX_W+1)'(DEPTH);

    logic              in_range;
    logic [WIDTH-1:0]  payload;
    option_max_t       next_word;
    logic              unused_hi;

    assign in_range = {1'b0, index} < DEPTH_EXT;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (index == IDX_W'(i)) payload = entries[i*WIDTH +: WIDTH];
        end
`ifdef INDEXED_ARRAY_STORE_BYPASS_EN
        // wr_commit is only set for in-range writes, so nothing out of range is forwarded.
        if (wr_commit && (wr_index == index)) payload = wr_data;
`endif
    end

`ifndef INDEXED_ARRAY_STORE_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_commit, wr_index, wr_data};
`endif

    assign next_word = in_range ? opt_some(payload_max_t'(payload)) : opt_none();
    assign unused_hi = ^next_word[MAX_WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            result <= {TAG_NONE, WIDTH'(0)};
        end else begin
            valid <= req;
            if (req) result <= {next_word[MAX_WIDTH], next_word[WIDTH-1:0]};
        end
    end

endmodule

// File: rtl/indexed_array_store.sv
// Flop-based DEPTH x WIDTH table with one write port and NUM_RD Option-encoded read channels.
// Build macro: INDEXED_ARRAY_STORE_BYPASS_EN (write-first on same-index read/write).
module indexed_array_store
    import indexed_array_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 3,
    parameter int IDX_W     = 16,
    parameter int NUM_RD    = 2,
    parameter int INIT_BASE = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_index,
    input  logic [WIDTH-1:0]            wr_data,
    output logic                        wr_oob,
    input  logic [NUM_RD-1:0]           rd_req,
    input  logic [NUM_RD*IDX_W-1:0]     rd_index,
    output logic [NUM_RD-1:0]           rd_valid,
    output logic [NUM_RD*(WIDTH+1)-1:0] rd_result
);

    localparam logic [IDX_W:0] DEPTH_EXT = (IDX_W+1)'(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH*WIDTH-1:0] entries;
    logic                   wr_in_range;
    logic                   wr_commit;

    assign wr_in_range = {1'b0, wr_index} < DEPTH_EXT;
    assign wr_commit   = wr_en && wr_in_range;

    // NOTE: the table is reset explicitly because its power-on content is part of the contract.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(INIT_BASE + i);
        end else if (wr_commit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_index == IDX_W'(i)) mem[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_oob <= 1'b0;
        else     wr_oob <= wr_en && !wr_in_range;
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_flat
        assign entries[e*WIDTH +: WIDTH] = mem[e];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        array_read_port #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .req       (rd_req[k]),
            .index     (rd_index[k*IDX_W +: IDX_W]),
            .entries   (entries),
            .wr_commit (wr_commit),
            .wr_index  (wr_index),
            .wr_data   (wr_data),
            .valid     (rd_valid[k]),
            .result    (rd_result[k*(WIDTH+1) +: WIDTH+1])
        );
    end

endmodule

// File: tb/tb_indexed_array_store.sv
// Bench for indexed_array_store: directed table, randomized run against a table model, reset mid-flight.
// Honors INDEXED_ARRAY_STORE_BYPASS_EN for the same-cycle read/write expectation.
module tb_indexed_array_store;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 3;
    localparam int IDX_W     = 16;
    localparam int NUM_RD    = 2;
    localparam int INIT_BASE = 11;
`ifdef INDEXED_ARRAY_STORE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam logic [WIDTH:0] NONE = {1'b1, 16'h0000};

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        wr_en;
    logic [IDX_W-1:0]            wr_index;
    logic [WIDTH-1:0]            wr_data;
    logic                        wr_oob;
    logic [NUM_RD-1:0]           rd_req;
    logic [NUM_RD*IDX_W-1:0]     rd_index;
    logic [NUM_RD-1:0]           rd_valid;
    logic [NUM_RD*(WIDTH+1)-1:0] rd_result;

    indexed_array_store #(
        .WIDTH (WIDTH), .DEPTH (DEPTH), .IDX_W (IDX_W), .NUM_RD (NUM_RD), .INIT_BASE (INIT_BASE)
    ) dut (
        .clk (clk), .rst (rst),
        .wr_en (wr_en), .wr_index (wr_index), .wr_data (wr_data), .wr_oob (wr_oob),
        .rd_req (rd_req), .rd_index (rd_index), .rd_valid (rd_valid), .rd_result (rd_result)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: plain array of entry values plus the expected registered outputs.
    int unsigned     model_mem [DEPTH];
    logic [1:0]      exp_valid;
    logic [WIDTH:0]  exp_res [NUM_RD];
    logic            exp_oob;

    typedef struct {
        logic        we;
        logic [15:0] widx;
        logic [15:0] wdata;
        logic [1:0]  req;
        logic [15:0] i0;
        logic [15:0] i1;
        logic [1:0]  ev;
        logic [16:0] e0;
        logic [16:0] e1;
        logic        eoob;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [16:0] some(input logic [15:0] v);
        return {1'b0, v};
    endfunction

    function automatic vec_t mk(input logic we, input logic [15:0] widx, input logic [15:0] wdata,
                                input logic [1:0] req, input logic [15:0] i0, input logic [15:0] i1,
                                input logic [1:0] ev, input logic [16:0] e0, input logic [16:0] e1,
                                input logic eoob);
        vec_t v;
        v.we = we; v.widx = widx; v.wdata = wdata; v.req = req; v.i0 = i0; v.i1 = i1;
        v.ev = ev; v.e0 = e0; v.e1 = e1; v.eoob = eoob;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = (INIT_BASE + i) & 32'hFFFF;
        exp_valid = '0;
        exp_oob   = 1'b0;
        for (int k = 0; k < NUM_RD; k++) exp_res[k] = NONE;
    endtask

    // Drive one cycle of stimulus, advance the model, then sample just after the edge.
    task automatic apply(input logic we, input logic [15:0] widx, input logic [15:0] wdata,
                         input logic [1:0] req, input logic [15:0] i0, input logic [15:0] i1);
        int unsigned idx;
        int unsigned val;
        wr_en = we; wr_index = widx; wr_data = wdata;
        rd_req = req; rd_index = {i1, i0};
        for (int k = 0; k < NUM_RD; k++) begin
            idx = (k == 0) ? i0 : i1;
            exp_valid[k] = req[k];
            if (req[k]) begin
                if (idx < DEPTH) begin
                    val = model_mem[idx];
                    if (BYPASS && we && widx == idx) val = wdata;
                    exp_res[k] = some(val[15:0]);
                end else begin
                    exp_res[k] = NONE;
                end
            end
        end
        exp_oob = we && (widx >= DEPTH);
        if (we && widx < DEPTH) model_mem[widx] = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, 32'(rd_valid), 32'(exp_valid));
        check({tag, ".res0"},  32'(rd_result[16:0]),  32'(exp_res[0]));
        check({tag, ".res1"},  32'(rd_result[33:17]), 32'(exp_res[1]));
        check({tag, ".oob"},   32'(wr_oob), 32'(exp_oob));
    endtask

    function automatic logic [15:0] rand_idx();
        case ($urandom_range(0, 5))
            0, 1, 2: return 16'($urandom_range(0, DEPTH - 1));
            3:       return 16'(DEPTH);
            4:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_index = '0; wr_data = '0; rd_req = '0; rd_index = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", 32'(rd_valid), 32'h0);
        check("reset.res0", 32'(rd_result[16:0]), 32'(NONE));
        check("reset.res1", 32'(rd_result[33:17]), 32'(NONE));
        check("reset.oob", 32'(wr_oob), 32'h0);
        rst = 1'b0;

        vecs[0]  = mk(0, 0, 0,           2'b01, 0, 0,          2'b01, some(11), NONE, 0);
        vecs[1]  = mk(0, 0, 0,           2'b01, 1, 0,          2'b01, some(12), NONE, 0);
        vecs[2]  = mk(0, 0, 0,           2'b01, 2, 0,          2'b01, some(13), NONE, 0);
        vecs[3]  = mk(0, 0, 0,           2'b11, 3, 16'hFFFF,   2'b11, NONE, NONE, 0);
        vecs[4]  = mk(1, 1, 16'h00AA,    2'b00, 0, 0,          2'b00, NONE, NONE, 0);
        vecs[5]  = mk(0, 0, 0,           2'b10, 0, 1,          2'b10, NONE, some(16'h00AA), 0);
        vecs[6]  = mk(1, 5, 16'h1234,    2'b01, 1, 0,          2'b01, some(16'h00AA), some(16'h00AA), 1);
        vecs[7]  = mk(0, 0, 0,           2'b00, 0, 0,          2'b00, some(16'h00AA), some(16'h00AA), 0);
        vecs[8]  = mk(0, 0, 0,           2'b11, 0, 2,          2'b11, some(11), some(13), 0);
        vecs[9]  = mk(1, 2, 16'h0055,    2'b01, 2, 0,          2'b01,
                      BYPASS ? some(16'h0055) : some(13), some(13), 0);
        vecs[10] = mk(0, 0, 0,           2'b01, 2, 0,          2'b01, some(16'h0055), some(13), 0);
        for (int i = 11; i < 14; i++)
            vecs[i] = mk(0, 0, 0,        2'b11, 0, 0,          2'b11, some(11), some(11), 0);

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].we, vecs[i].widx, vecs[i].wdata, vecs[i].req, vecs[i].i0, vecs[i].i1);
            check($sformatf("v%0d.valid", i), 32'(rd_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d.res0", i), 32'(rd_result[16:0]), 32'(vecs[i].e0));
            check($sformatf("v%0d.res1", i), 32'(rd_result[33:17]), 32'(vecs[i].e1));
            check($sformatf("v%0d.oob", i), 32'(wr_oob), 32'(vecs[i].eoob));
        end

        for (int c = 0; c < 400; c++) begin
            apply(1'($urandom), rand_idx(), 16'($urandom), 2'($urandom), rand_idx(), rand_idx());
            check_model($sformatf("rnd%0d", c));
        end

        // Reset lands between a request and its response; the in-flight write is lost too.
        wr_en = 1'b1; wr_index = 16'd1; wr_data = 16'h0077;
        rd_req = 2'b11; rd_index = {16'd0, 16'd1};
        #2 rst = 1'b1;
        #1;
        check("midrst.valid", 32'(rd_valid), 32'h0);
        check("midrst.res0", 32'(rd_result[16:0]), 32'(NONE));
        check("midrst.res1", 32'(rd_result[33:17]), 32'(NONE));
        check("midrst.oob", 32'(wr_oob), 32'h0);
        wr_en = 1'b0; rd_req = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        apply(0, 0, 0, 2'b11, 1, 2);
        check("postrst.res0", 32'(rd_result[16:0]), 32'(some(12)));
        check_model("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
